// File: rtl/native_to_axi4_master_pkg.sv
// Shared types and constants for the native-app to AXI4 master bridge.
// Holds the native command codes, bridge FSM states and fixed AXI field values.
package native_axi_pkg;

    typedef enum logic [2:0] {
        NATIVE_WR = 3'b000,
        NATIVE_RD = 3'b001
    } native_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_XFER = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4
    } bridge_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // AXI size encoding for a single full-width beat
    function automatic logic [2:0] axi_size_from_width(input int unsigned data_width);
        return 3'($clog2(data_width / 32'd8));
    endfunction

endpackage

// File: rtl/native_to_axi4_master_if.sv
// AXI4 bus bundle between the bridge (master) and any AXI4 slave.
// Single clock; axi_aclk must come from the same net as the bridge clock.
interface native_to_axi4_master_if #(
    parameter int ADDR_WIDTH = 29,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 4
) (
    input logic axi_aclk
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        input  axi_aclk,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  axi_aclk,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/native_to_axi4_master_fifo.sv
// First-word fall-through synchronous FIFO used for native commands and write data.
// Push+pop together on a full or empty FIFO leaves occupancy unchanged; a lone push while full is dropped.
module native_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW:0]      wr_ptr_r;
    logic [PW:0]      rd_ptr_r;
    logic             push_s;
    logic             pop_s;

    assign empty  = (wr_ptr_r == rd_ptr_r);
    assign full   = (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]) && (wr_ptr_r[PW] != rd_ptr_r[PW]);
    // an empty FIFO passes din straight through when pushed and popped together
    assign pop_s  = rd_en && (!empty || wr_en);
    assign push_s = wr_en && (!full || rd_en);
    assign dout   = empty ? din : mem_r[rd_ptr_r[PW-1:0]];

    // read/write pointer update
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
            end
        end
    end

    // storage array write port
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/native_to_axi4_master.sv
// Bridge from a DDR-controller native app interface to an AXI4 master port.
// Each native command becomes one single-beat AXI4 transaction, in order, one outstanding at a time.
module native_to_axi4_master
    import native_axi_pkg::*;
#(
    parameter int ADDR_WIDTH   = 27,
    parameter int DATA_WIDTH   = 256,
    parameter int ADDR_SHIFT   = 2,
    parameter int ID_WIDTH     = 4,
    parameter int AXI_ID       = 0,
    parameter int CMD_DEPTH    = 4,
    parameter int WDF_DEPTH    = 4,
    parameter int CALIB_CYCLES = 16
) (
    input  logic                      clock,
    input  logic                      rst,
    native_to_axi4_master_if.master   axi_inf,
    input  logic [ADDR_WIDTH-1:0]     app_addr,
    input  logic [2:0]                app_cmd,
    input  logic                      app_en,
    output logic                      app_rdy,
    input  logic [DATA_WIDTH-1:0]     app_wdf_data,
    input  logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
    input  logic                      app_wdf_wren,
    input  logic                      app_wdf_end,
    output logic                      app_wdf_rdy,
    output logic [DATA_WIDTH-1:0]     app_rd_data,
    output logic                      app_rd_data_valid,
    output logic                      app_rd_data_end,
    output logic                      init_calib_complete,
    output logic                      resp_err
);
    localparam int          STRB_W   = DATA_WIDTH / 8;
    localparam int          CMD_W    = ADDR_WIDTH + 3;
    localparam int          WDF_W    = DATA_WIDTH + STRB_W;
    localparam int          CALW     = $clog2(CALIB_CYCLES + 1);
    localparam logic [2:0]  AXI_SIZE = axi_size_from_width(DATA_WIDTH);

    logic [CALW-1:0]        calib_cnt_r;
    logic                   calib_done_r;
    logic                   cmd_push_s, cmd_pop_s, cmd_full_s, cmd_empty_s;
    logic                   wdf_push_s, wdf_pop_s, wdf_full_s, wdf_empty_s;
    logic [CMD_W-1:0]       cmd_dout_s;
    logic [WDF_W-1:0]       wdf_dout_s;
    logic [2:0]             cmd_op_s;
    logic [ADDR_WIDTH-1:0]  cmd_addr_s;
    logic                   aw_done_s, w_done_s;
    logic                   unused_s;

    bridge_state_e          state_r, state_nxt;
    logic                   awvalid_r, awvalid_nxt;
    logic                   wvalid_r, wvalid_nxt;
    logic                   arvalid_r, arvalid_nxt;
    logic                   bready_r, bready_nxt;
    logic                   rready_r, rready_nxt;
    logic [ADDR_WIDTH-1:0]  addr_r, addr_nxt;
    logic [DATA_WIDTH-1:0]  wdata_r, wdata_nxt;
    logic [STRB_W-1:0]      wstrb_r, wstrb_nxt;
    logic [DATA_WIDTH-1:0]  rd_data_r, rd_data_nxt;
    logic                   rd_valid_r, rd_valid_nxt;
    logic                   resp_err_r, resp_err_nxt;

    assign app_rdy     = calib_done_r && !cmd_full_s;
    assign app_wdf_rdy = calib_done_r && !wdf_full_s;
    assign cmd_push_s  = app_en && app_rdy;
    assign wdf_push_s  = app_wdf_wren && app_wdf_rdy;
    assign cmd_op_s    = cmd_dout_s[ADDR_WIDTH +: 3];
    assign cmd_addr_s  = cmd_dout_s[ADDR_WIDTH-1:0];
    assign aw_done_s   = !awvalid_r || axi_inf.awready;
    assign w_done_s    = !wvalid_r || axi_inf.wready;
    // IDs and rlast carry nothing for single-beat in-order traffic; end is implied per beat
    assign unused_s    = ^{axi_inf.bid, axi_inf.rid, axi_inf.rlast, axi_inf.axi_aclk, app_wdf_end};

    native_sync_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(CMD_W)) u_cmd_fifo (
        .clock (clock),
        .rst   (rst),
        .wr_en (cmd_push_s),
        .din   ({app_cmd, app_addr}),
        .rd_en (cmd_pop_s),
        .dout  (cmd_dout_s),
        .full  (cmd_full_s),
        .empty (cmd_empty_s)
    );

    native_sync_fifo #(.DEPTH(WDF_DEPTH), .WIDTH(WDF_W)) u_wdf_fifo (
        .clock (clock),
        .rst   (rst),
        .wr_en (wdf_push_s),
        .din   ({app_wdf_data, app_wdf_mask}),
        .rd_en (wdf_pop_s),
        .dout  (wdf_dout_s),
        .full  (wdf_full_s),
        .empty (wdf_empty_s)
    );

    // calibration delay: done goes high on the CALIB_CYCLES-th clock after reset release
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            calib_cnt_r  <= '0;
            calib_done_r <= 1'b0;
        end else if (!calib_done_r) begin
            calib_cnt_r <= calib_cnt_r + CALW'(1'b1);
            if (calib_cnt_r == CALW'(CALIB_CYCLES - 32'sd1)) begin
                calib_done_r <= 1'b1;
            end
        end
    end

    // next-state and datapath decode for the transaction FSM
    always_comb begin
        state_nxt    = state_r;
        awvalid_nxt  = awvalid_r;
        wvalid_nxt   = wvalid_r;
        arvalid_nxt  = arvalid_r;
        bready_nxt   = bready_r;
        rready_nxt   = rready_r;
        addr_nxt     = addr_r;
        wdata_nxt    = wdata_r;
        wstrb_nxt    = wstrb_r;
        rd_data_nxt  = rd_data_r;
        rd_valid_nxt = 1'b0;
        resp_err_nxt = resp_err_r;
        cmd_pop_s    = 1'b0;
        wdf_pop_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!cmd_empty_s) begin
                    case (cmd_op_s)
                        NATIVE_WR: begin
                            // a write waits at the head until its data beat is available
                            if (!wdf_empty_s) begin
                                cmd_pop_s   = 1'b1;
                                wdf_pop_s   = 1'b1;
                                addr_nxt    = cmd_addr_s;
                                wdata_nxt   = wdf_dout_s[STRB_W +: DATA_WIDTH];
                                wstrb_nxt   = ~wdf_dout_s[STRB_W-1:0];
                                awvalid_nxt = 1'b1;
                                wvalid_nxt  = 1'b1;
                                state_nxt   = ST_WR_XFER;
                            end else begin
                                state_nxt   = ST_IDLE;
                            end
                        end
                        NATIVE_RD: begin
                            cmd_pop_s   = 1'b1;
                            addr_nxt    = cmd_addr_s;
                            arvalid_nxt = 1'b1;
                            state_nxt   = ST_RD_ADDR;
                        end
                        default: begin
                            cmd_pop_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WR_XFER: begin
                if (aw_done_s) begin
                    awvalid_nxt = 1'b0;
                end else begin
                    awvalid_nxt = 1'b1;
                end
                if (w_done_s) begin
                    wvalid_nxt = 1'b0;
                end else begin
                    wvalid_nxt = 1'b1;
                end
                if (aw_done_s && w_done_s) begin
                    bready_nxt = 1'b1;
                    state_nxt  = ST_WR_RESP;
                end else begin
                    state_nxt  = ST_WR_XFER;
                end
            end
            ST_WR_RESP: begin
                if (axi_inf.bvalid) begin
                    bready_nxt = 1'b0;
                    state_nxt  = ST_IDLE;
                    if (axi_inf.bresp != RESP_OKAY) begin
                        resp_err_nxt = 1'b1;
                    end else begin
                        resp_err_nxt = resp_err_r;
                    end
                end else begin
                    state_nxt = ST_WR_RESP;
                end
            end
            ST_RD_ADDR: begin
                if (axi_inf.arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = ST_RD_DATA;
                end else begin
                    state_nxt   = ST_RD_ADDR;
                end
            end
            ST_RD_DATA: begin
                if (axi_inf.rvalid) begin
                    rready_nxt   = 1'b0;
                    rd_data_nxt  = axi_inf.rdata;
                    rd_valid_nxt = 1'b1;
                    state_nxt    = ST_IDLE;
                    if (axi_inf.rresp != RESP_OKAY) begin
                        resp_err_nxt = 1'b1;
                    end else begin
                        resp_err_nxt = resp_err_r;
                    end
                end else begin
                    state_nxt = ST_RD_DATA;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                awvalid_nxt = 1'b0;
                wvalid_nxt  = 1'b0;
                arvalid_nxt = 1'b0;
                bready_nxt  = 1'b0;
                rready_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state, channel handshake flags and holding registers
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            awvalid_r  <= 1'b0;
            wvalid_r   <= 1'b0;
            arvalid_r  <= 1'b0;
            bready_r   <= 1'b0;
            rready_r   <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            resp_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            awvalid_r  <= awvalid_nxt;
            wvalid_r   <= wvalid_nxt;
            arvalid_r  <= arvalid_nxt;
            bready_r   <= bready_nxt;
            rready_r   <= rready_nxt;
            addr_r     <= addr_nxt;
            wdata_r    <= wdata_nxt;
            wstrb_r    <= wstrb_nxt;
            rd_data_r  <= rd_data_nxt;
            rd_valid_r <= rd_valid_nxt;
            resp_err_r <= resp_err_nxt;
        end
    end

    assign axi_inf.awid    = ID_WIDTH'(AXI_ID);
    assign axi_inf.awaddr  = {addr_r, {ADDR_SHIFT{1'b0}}};
    assign axi_inf.awlen   = 8'd0;
    assign axi_inf.awsize  = AXI_SIZE;
    assign axi_inf.awburst = BURST_INCR;
    assign axi_inf.awvalid = awvalid_r;
    assign axi_inf.wdata   = wdata_r;
    assign axi_inf.wstrb   = wstrb_r;
    assign axi_inf.wlast   = 1'b1;
    assign axi_inf.wvalid  = wvalid_r;
    assign axi_inf.bready  = bready_r;
    assign axi_inf.arid    = ID_WIDTH'(AXI_ID);
    assign axi_inf.araddr  = {addr_r, {ADDR_SHIFT{1'b0}}};
    assign axi_inf.arlen   = 8'd0;
    assign axi_inf.arsize  = AXI_SIZE;
    assign axi_inf.arburst = BURST_INCR;
    assign axi_inf.arvalid = arvalid_r;
    assign axi_inf.rready  = rready_r;

    assign app_rd_data         = rd_data_r;
    assign app_rd_data_valid   = rd_valid_r;
    assign app_rd_data_end     = rd_valid_r;
    assign init_calib_complete = calib_done_r;
    assign resp_err            = resp_err_r;

endmodule

// File: tb/tb_native_to_axi4_master.sv
// Self-checking bench for native_to_axi4_master: an AXI4 slave model plus expectation queues
// filled as native commands/data are driven and drained as AXI beats and read returns appear.
module tb_native_to_axi4_master;
    import native_axi_pkg::*;

    localparam int AW  = 27;
    localparam int DW  = 256;
    localparam int SW  = 32;
    localparam int AXW = 29;

    logic          clock = 1'b0;
    logic          rst   = 1'b1;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          app_rdy;
    logic [DW-1:0] app_wdf_data;
    logic [SW-1:0] app_wdf_mask;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic          app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid;
    logic          app_rd_data_end;
    logic          init_calib_complete;
    logic          resp_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // slave behaviour knobs and observation counters
    logic          aw_en = 1'b1;
    logic          w_en  = 1'b1;
    logic [1:0]    bresp_cfg = 2'b00;
    logic [DW-1:0] rdata_cfg = '0;
    int            ar_stall_cfg = 0;
    int            aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0, b_hs_cnt = 0;
    int            r_hs_cycle = 0;

    logic [AXW-1:0] exp_aw_q[$];
    logic [AXW-1:0] exp_ar_q[$];
    logic [DW-1:0]  exp_w_q[$];
    logic [SW-1:0]  exp_strb_q[$];
    logic [DW-1:0]  exp_rd_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    native_to_axi4_master_if #(.ADDR_WIDTH(AXW), .DATA_WIDTH(DW), .ID_WIDTH(4)) axi_bus (.axi_aclk(clock));

    native_to_axi4_master dut (
        .clock               (clock),
        .rst                 (rst),
        .axi_inf             (axi_bus),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .init_calib_complete (init_calib_complete),
        .resp_err            (resp_err)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr);
        int n;
        n = 0;
        @(negedge clock);
        app_cmd  = cmd;
        app_addr = addr;
        app_en   = 1'b1;
        while (!app_rdy && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_eq("cmd_accept", {255'd0, app_rdy}, 256'd1);
        if (cmd == 3'b000) begin
            exp_aw_q.push_back({addr, 2'b00});
        end
        if (cmd == 3'b001) begin
            exp_ar_q.push_back({addr, 2'b00});
            exp_rd_q.push_back(rdata_cfg);
        end
        @(posedge clock);
        #1;
        app_en = 1'b0;
    endtask

    task automatic send_data(input logic [DW-1:0] d, input logic [SW-1:0] m);
        int n;
        n = 0;
        @(negedge clock);
        app_wdf_data = d;
        app_wdf_mask = m;
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        while (!app_wdf_rdy && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_eq("wdf_accept", {255'd0, app_wdf_rdy}, 256'd1);
        exp_w_q.push_back(d);
        exp_strb_q.push_back(~m);
        @(posedge clock);
        #1;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int  n;
        logic busy;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            busy = (exp_aw_q.size() != 0) || (exp_w_q.size() != 0) || (exp_ar_q.size() != 0) ||
                   (exp_rd_q.size() != 0) || axi_bus.awvalid || axi_bus.wvalid || axi_bus.arvalid ||
                   axi_bus.bvalid || axi_bus.rvalid || axi_bus.bready || axi_bus.rready;
        end while (busy && n < 500);
        check_eq({tag, "_drain_busy"}, {255'd0, busy}, 256'd0);
    endtask

    // AXI4 slave model: readies and responses driven at negedge, handshakes checked against the queues
    initial begin : slave
        logic aw_got, w_got, b_pend, b_hs, r_pend, r_hs, ar_active;
        int   ar_wait;
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; b_hs = 1'b0;
        r_pend = 1'b0; r_hs = 1'b0; ar_active = 1'b0; ar_wait = 0;
        axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.arready = 1'b0;
        axi_bus.bvalid = 1'b0; axi_bus.bresp = 2'b00; axi_bus.bid = 4'd0;
        axi_bus.rvalid = 1'b0; axi_bus.rresp = 2'b00; axi_bus.rid = 4'd0;
        axi_bus.rlast = 1'b0; axi_bus.rdata = '0;
        forever begin
            @(negedge clock);
            if (rst) begin
                aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; b_hs = 1'b0;
                r_pend = 1'b0; r_hs = 1'b0; ar_active = 1'b0;
                axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.arready = 1'b0;
                axi_bus.bvalid = 1'b0; axi_bus.rvalid = 1'b0;
            end else begin
                if (b_hs) begin axi_bus.bvalid = 1'b0; b_hs = 1'b0; end
                if (r_hs) begin axi_bus.rvalid = 1'b0; r_hs = 1'b0; end
                if (b_pend && !axi_bus.bvalid) begin
                    axi_bus.bvalid = 1'b1; axi_bus.bresp = bresp_cfg; b_pend = 1'b0;
                end
                if (r_pend && !axi_bus.rvalid) begin
                    axi_bus.rvalid = 1'b1; axi_bus.rdata = rdata_cfg; axi_bus.rresp = 2'b00;
                    axi_bus.rlast = 1'b1; r_pend = 1'b0;
                end
                axi_bus.awready = aw_en;
                axi_bus.wready  = w_en;
                if (axi_bus.arvalid) begin
                    if (!ar_active) begin ar_active = 1'b1; ar_wait = ar_stall_cfg; end
                    if (ar_wait > 0) begin axi_bus.arready = 1'b0; ar_wait--; end
                    else axi_bus.arready = 1'b1;
                end else begin
                    axi_bus.arready = 1'b0;
                end
                if (axi_bus.awvalid && axi_bus.awready) begin
                    aw_hs_cnt++;
                    aw_got = 1'b1;
                    if (exp_aw_q.size() == 0) check_eq("aw_unexpected", {255'd0, axi_bus.awvalid}, 256'd0);
                    else check_eq("awaddr", axi_bus.awaddr, exp_aw_q.pop_front());
                    check_eq("awsize", axi_bus.awsize, 256'd5);
                    check_eq("awlen_burst_id", {axi_bus.awlen, axi_bus.awburst, axi_bus.awid}, {8'd0, 2'b01, 4'd0});
                end
                if (axi_bus.wvalid && axi_bus.wready) begin
                    w_hs_cnt++;
                    w_got = 1'b1;
                    if (exp_w_q.size() == 0) check_eq("w_unexpected", {255'd0, axi_bus.wvalid}, 256'd0);
                    else begin
                        check_eq("wdata", axi_bus.wdata, exp_w_q.pop_front());
                        check_eq("wstrb", axi_bus.wstrb, exp_strb_q.pop_front());
                    end
                    check_eq("wlast", {255'd0, axi_bus.wlast}, 256'd1);
                end
                if (aw_got && w_got) begin b_pend = 1'b1; aw_got = 1'b0; w_got = 1'b0; end
                if (axi_bus.bvalid && axi_bus.bready) begin b_hs = 1'b1; b_hs_cnt++; end
                if (axi_bus.arvalid && axi_bus.arready) begin
                    ar_hs_cnt++;
                    ar_active = 1'b0;
                    r_pend = 1'b1;
                    if (exp_ar_q.size() == 0) check_eq("ar_unexpected", {255'd0, axi_bus.arvalid}, 256'd0);
                    else check_eq("araddr", axi_bus.araddr, exp_ar_q.pop_front());
                    check_eq("arsize_len_burst", {axi_bus.arsize, axi_bus.arlen, axi_bus.arburst}, {3'd5, 8'd0, 2'b01});
                end
                if (axi_bus.rvalid && axi_bus.rready) begin r_hs = 1'b1; r_hs_cycle = cyc; end
            end
        end
    end

    // native read-return monitor: one-cycle strobe, one cycle after the R handshake
    initial begin : rd_mon
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (app_rd_data_valid === 1'b1) begin
                check_eq("rd_pulse_width", {255'd0, prev_valid}, 256'd0);
                check_eq("rd_data_end", {255'd0, app_rd_data_end}, 256'd1);
                check_eq("rd_latency", 256'(cyc - r_hs_cycle), 256'd1);
                if (exp_rd_q.size() == 0) check_eq("rd_unexpected", {255'd0, app_rd_data_valid}, 256'd0);
                else check_eq("app_rd_data", app_rd_data, exp_rd_q.pop_front());
            end
            prev_valid = app_rd_data_valid;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int aw0, hs0;
        app_en = 1'b0; app_cmd = 3'b000; app_addr = '0;
        app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("reset_outputs",
                 {249'd0, axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid, axi_bus.bready,
                  axi_bus.rready, app_rd_data_valid, resp_err}, 256'd0);
        check_eq("reset_calib_rdy", {253'd0, init_calib_complete, app_rdy, app_wdf_rdy}, 256'd0);
        rst = 1'b0;

        // calibration: still low after 15 clocks, high after the 16th
        repeat (15) @(negedge clock);
        check_eq("calib_15", {254'd0, init_calib_complete, app_rdy}, 256'd0);
        @(negedge clock);
        check_eq("calib_16", {253'd0, init_calib_complete, app_rdy, app_wdf_rdy}, 256'd7);

        // single write, unmasked
        send_data({32{8'hA5}}, 32'h0000_0000);
        send_cmd(3'b000, 27'h40);
        wait_idle("wr1");
        check_eq("wr1_bcount", 256'(b_hs_cnt), 256'd1);
        check_eq("wr1_resp_err", {255'd0, resp_err}, 256'd0);

        // data ahead of command, then a command whose data arrives late
        send_data({8{32'hDEAD_BEEF}}, 32'h0000_00FF);
        repeat (3) @(negedge clock);
        send_cmd(3'b000, 27'h44);
        wait_idle("wr2");
        aw0 = aw_hs_cnt;
        send_cmd(3'b000, 27'h48);
        repeat (6) @(negedge clock);
        check_eq("no_aw_without_data", 256'(aw_hs_cnt), 256'(aw0));
        check_eq("awvalid_idle", {255'd0, axi_bus.awvalid}, 256'd0);
        send_data({16{16'h1357}}, 32'hF0F0_0F0F);
        wait_idle("wr3");
        check_eq("wr3_aw_count", 256'(aw_hs_cnt), 256'(aw0 + 1));

        // read with a 5-cycle arready stall
        ar_stall_cfg = 5;
        rdata_cfg    = 256'h1234;
        send_cmd(3'b001, 27'h80);
        wait_idle("rd1");
        check_eq("rd1_ar_count", 256'(ar_hs_cnt), 256'd1);
        ar_stall_cfg = 0;

        // fill the command FIFO while AW is blocked, then drain in order
        aw_en = 1'b0;
        aw0   = aw_hs_cnt;
        for (int i = 0; i < 4; i++) send_cmd(3'b000, 27'(32'h100 + 32'(i) * 32'd8));
        @(negedge clock);
        check_eq("cmd_full_rdy", {254'd0, app_rdy, app_wdf_rdy}, 256'd1);
        for (int i = 0; i < 4; i++) send_data({32{8'(8'h10 + 8'(i))}}, 32'(i));
        repeat (5) @(negedge clock);
        check_eq("aw_blocked", 256'(aw_hs_cnt), 256'(aw0));
        aw_en = 1'b1;
        wait_idle("fill");
        check_eq("fill_aw_count", 256'(aw_hs_cnt), 256'(aw0 + 4));

        // read and write back to back, zero-wait
        rdata_cfg = {4{64'hCAFE_F00D_0123_4567}};
        send_cmd(3'b001, 27'h7FF_FFFF);
        send_data({32{8'h5A}}, 32'hFFFF_FFFF);
        send_cmd(3'b000, 27'h3);
        wait_idle("mix");
        check_eq("mix_resp_err", {255'd0, resp_err}, 256'd0);

        // SLVERR on B sets the sticky error
        bresp_cfg = 2'b10;
        send_data({32{8'h33}}, 32'h0);
        send_cmd(3'b000, 27'h200);
        wait_idle("berr");
        check_eq("berr_resp_err", {255'd0, resp_err}, 256'd1);
        bresp_cfg = 2'b00;

        // an unknown command is consumed without AXI traffic
        hs0 = aw_hs_cnt + w_hs_cnt + ar_hs_cnt;
        send_cmd(3'b111, 27'h300);
        repeat (6) @(negedge clock);
        check_eq("cmd111_no_traffic", 256'(aw_hs_cnt + w_hs_cnt + ar_hs_cnt), 256'(hs0));
        check_eq("cmd111_consumed", {255'd0, app_rdy}, 256'd1);
        send_data({32{8'h77}}, 32'h0);
        send_cmd(3'b000, 27'h204);
        wait_idle("after111");
        check_eq("resp_err_sticky", {255'd0, resp_err}, 256'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
